// File: rtl/v_lane_splitter_if.sv
// Bus bundle for v_lane_splitter.
//   DIN/DIN_VALID/DIN_LAST/DIN_READY : serial input stream, LSB first
//   DO_1/DO_2/DO_LAST/DO_TRUNC       : lane pair at the head of the output FIFO
//   DO_VALID/DO_READY                : output handshake
// slave  : the splitter's view (consumes DIN, produces DO_*)
// master : the environment's view (produces DIN, consumes DO_*)
interface v_lane_splitter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             DIN;
  logic             DIN_VALID;
  logic             DIN_LAST;
  logic             DIN_READY;
  logic [WIDTH-1:0] DO_1;
  logic [WIDTH-1:0] DO_2;
  logic             DO_LAST;
  logic             DO_TRUNC;
  logic             DO_VALID;
  logic             DO_READY;

  modport slave (
    input  DIN, DIN_VALID, DIN_LAST, DO_READY,
    output DIN_READY, DO_1, DO_2, DO_LAST, DO_TRUNC, DO_VALID
  );

  modport master (
    output DIN, DIN_VALID, DIN_LAST, DO_READY,
    input  DIN_READY, DO_1, DO_2, DO_LAST, DO_TRUNC, DO_VALID
  );
endinterface

// File: rtl/v_lane_splitter.sv
// Serial-to-dual-lane deserializer.
// Collects a 1-bit stream LSB first: WIDTH bits into lane 1, then WIDTH bits
// into lane 2. A completed (or DIN_LAST-truncated) pair is pushed into a
// DEPTH-entry FIFO whose head is presented on DO_* with DO_VALID/DO_READY.
// Ports:
//   CLK  : rising-edge clock
//   RSTN : synchronous reset, active low
//   bus  : v_lane_splitter_if.slave (input stream + output pair handshake)
module v_lane_splitter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  v_lane_splitter_if.slave     bus
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned EW = 2 * WIDTH + 2;

  typedef enum logic {FILL1, FILL2} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] lane1_q, lane1_d;
  logic [WIDTH-1:0] lane2_q, lane2_d;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [EW-1:0]    head_q, head_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] bit_c;
  logic             last_bit_c;
  logic             closing_c;
  logic             full_c;
  logic             din_ready_c;
  logic             accept_c;
  logic             pop_c;
  logic             push_c;
  logic [EW-1:0]    entry_c;

  // Handshake qualifiers; a same-cycle pop never frees space for a closing beat.
  always_comb begin
    bit_c       = WIDTH'(bus.DIN) << cnt_q;
    last_bit_c  = (cnt_q == CW'(WIDTH - 1));
    closing_c   = bus.DIN_LAST | ((state_q == FILL2) & last_bit_c);
    full_c      = (level_q == LW'(DEPTH));
    din_ready_c = RSTN & (~closing_c | ~full_c);
    accept_c    = bus.DIN_VALID & din_ready_c;
    pop_c       = valid_q & bus.DO_READY;
  end

  // Lane-fill FSM: next state, lane accumulation and pair formation.
  // Lane registers only ever hold bits below cnt, so OR-ing in the new bit
  // leaves unfilled positions zero for truncated pairs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lane1_d = lane1_q;
    lane2_d = lane2_q;
    push_c  = 1'b0;
    entry_c = '0;
    if (accept_c) begin
      case (state_q)
        FILL1: begin
          if (closing_c) begin
            push_c  = 1'b1;
            entry_c = {lane1_q | bit_c, WIDTH'(0), bus.DIN_LAST, 1'b1};
          end else if (last_bit_c) begin
            lane1_d = lane1_q | bit_c;
            cnt_d   = '0;
            state_d = FILL2;
          end else begin
            lane1_d = lane1_q | bit_c;
            cnt_d   = cnt_q + CW'(1);
          end
        end
        FILL2: begin
          if (closing_c) begin
            push_c  = 1'b1;
            entry_c = {lane1_q, lane2_q | bit_c, bus.DIN_LAST, ~last_bit_c};
          end else begin
            lane2_d = lane2_q | bit_c;
            cnt_d   = cnt_q + CW'(1);
          end
        end
        default: state_d = FILL1;
      endcase
      if (push_c) begin
        lane1_d = '0;
        lane2_d = '0;
        cnt_d   = '0;
        state_d = FILL1;
      end
    end
  end

  // FIFO bookkeeping; the head register holds its value once the FIFO drains.
  always_comb begin
    rd_ptr_d = pop_c ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + LW'(push_c) - LW'(pop_c);
    valid_d  = (level_d != '0);
    head_d   = head_q;
    if (valid_d) begin
      // Next head is the entry being written only when it is the sole occupant.
      head_d = (push_c && (rd_ptr_d == wr_ptr_q)) ? entry_c : mem_q[rd_ptr_d];
    end
  end

  // State and storage registers.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q  <= FILL1;
      cnt_q    <= '0;
      lane1_q  <= '0;
      lane2_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lane1_q  <= lane1_d;
      lane2_q  <= lane2_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
      if (push_c) begin
        mem_q[wr_ptr_q] <= entry_c;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
    end
  end

  assign bus.DIN_READY = din_ready_c;
  assign bus.DO_1      = head_q[EW-1 -: WIDTH];
  assign bus.DO_2      = head_q[2 +: WIDTH];
  assign bus.DO_LAST   = head_q[1];
  assign bus.DO_TRUNC  = head_q[0];
  assign bus.DO_VALID  = valid_q;

endmodule
